conv_out_collect: RTL

Sink-side partner of the conv output-valid combiner. Takes the registered conv result stream (in_vld, in_data) and counts output-feature-map column and row. Packs PACK results per word and writes the words to the output feature buffer through a valid/ready write port. Signals frame completion and flags overflow when the buffer cannot keep up.

---
 rtl/conv_out_collect_pkg.sv | 25 ++
 rtl/conv_out_wr_reg.sv | 54 +++++
 rtl/conv_out_collect.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/conv_out_collect_pkg.sv
// Shared conv package: FSM state encoding, default geometry and a small
// helper that sizes counters so a dimension of 1 still gets a 1-bit counter.
package conv_out_collect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int PACK_DEF   = 4;
  localparam int OUT_W_DEF  = 26;
  localparam int OUT_H_DEF  = 26;
  localparam int ADDR_W_DEF = 10;

  // Width of one lane slice inside a packed buffer word.
  localparam int LANE_W = DATA_W_DEF;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_out_wr_reg.sv
// Single-entry write holding register for the output feature buffer.
// Handshake: a word transfers on a cycle where wr_en & wr_ready are both
// high; while wr_en is high and wr_ready low, wr_en/wr_addr/wr_data hold.
// A load arriving while the held word is not leaving is dropped and sets ovf.
module conv_out_wr_reg #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              ovf
);

  logic accept;

  assign accept = wr_en & wr_ready;

  // Hold / replace the pending word, advance the address on acceptance,
  // and latch overflow when a new word has nowhere to go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ovf     <= 1'b0;
    end else begin
      if (clr) begin
        wr_addr <= '0;
        ovf     <= 1'b0;
      end else if (accept) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end

      if (load && (!wr_en || accept)) begin
        wr_en   <= 1'b1;
        wr_data <= load_data;
      end else if (accept) begin
        wr_en <= 1'b0;
      end

      if (load && wr_en && !accept) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_out_collect.sv
// Conv output collector: counts output-map column/row, packs PACK results
// per buffer word (lane 0 = earliest) and hands words to conv_out_wr_reg.
// Optional build macro CONV_OUT_ROW_PAD_EN: every row starts a fresh word,
// the last word of each row is zero-padded.
module conv_out_collect
  import conv_out_collect_pkg::*;
#(
  parameter int DATA_W = LANE_W,
  parameter int PACK   = PACK_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int OUT_H  = OUT_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_vld,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   wr_en,
  input  logic                   wr_ready,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [PACK*DATA_W-1:0] wr_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   ovf,
  output state_t                 state_dbg
);

  localparam int WORD_W  = PACK * DATA_W;
  localparam int COL_W   = cnt_w(OUT_W);
  localparam int ROW_W   = cnt_w(OUT_H);
  localparam int LANE_CW = $clog2(PACK);

  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(OUT_H - 1);
  localparam logic [LANE_CW-1:0] LANE_LAST = LANE_CW'(PACK - 1);

`ifdef CONV_OUT_ROW_PAD_EN
  localparam bit ROW_PAD = 1'b1;
`else
  localparam bit ROW_PAD = 1'b0;
`endif

  state_t              state_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic [LANE_CW-1:0]  lane_q;
  logic [WORD_W-1:0]   pack_q;
  logic                busy_q;
  logic                done_q;

  logic                take;
  logic                last_col;
  logic                last_pix;
  logic                word_end;
  logic                load;
  logic                clr;
  logic                accept;
  logic [WORD_W-1:0]   word_next;

  assign take     = (state_q == ST_COLLECT) && in_vld;
  assign last_col = (col_q == COL_LAST);
  assign last_pix = last_col && (row_q == ROW_LAST);
  assign word_end = (lane_q == LANE_LAST) || last_pix || (ROW_PAD && last_col);
  assign load     = take && word_end;
  assign clr      = (state_q == ST_IDLE) && start;
  assign accept   = wr_en && wr_ready;

  // Pack register with the incoming result dropped into the current lane;
  // lanes above the current one stay zero because pack_q clears per word.
  always_comb begin
    word_next = pack_q;
    for (int k = 0; k < PACK; k++) begin
      if (lane_q == LANE_CW'(k)) begin
        word_next[k*DATA_W +: DATA_W] = in_data;
      end
    end
  end

  // Frame FSM: counters, lane packing and registered busy/frame_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_COLLECT;
            busy_q  <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
            lane_q  <= '0;
            pack_q  <= '0;
          end
        end
        ST_COLLECT: begin
          if (in_vld) begin
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + ROW_W'(1);
            end else begin
              col_q <= col_q + COL_W'(1);
            end
            if (word_end) begin
              pack_q <= '0;
              lane_q <= '0;
            end else begin
              pack_q <= word_next;
              lane_q <= lane_q + LANE_CW'(1);
            end
            if (last_pix) begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (!wr_en || accept) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  conv_out_wr_reg #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_wr_reg (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .load      (load),
    .load_data (word_next),
    .wr_ready  (wr_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ovf       (ovf)
  );

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign state_dbg  = state_q;

endmodule
